// File: rtl/fp_mul_arbiter.sv
// Round-robin (or fixed-priority with FP_MUL_ARB_FIXED_PRIO_EN) sharing of one pipelined
// multiplier; credit-gated issue, tag tracking through LAT cycles, FWFT response FIFO.
module fp_mul_arbiter #(
   parameter int N          = 16,
   parameter int NUM_REQ    = 4,
   parameter int LAT        = 3,
   parameter int FIFO_DEPTH = 8,
   localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   output logic [NUM_REQ-1:0]   req_ready,
   input  logic [NUM_REQ*N-1:0] req_a,
   input  logic [NUM_REQ*N-1:0] req_b,
   output logic [N-1:0]         mul_a,
   output logic [N-1:0]         mul_b,
   input  logic [N-1:0]         mul_result,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [N-1:0]         resp_data,
   output logic [ID_W-1:0]      resp_id,
   output logic                 busy
);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
      return (id == ID_W'(NUM_REQ - 1)) ? '0 : id + 1'b1;
   endfunction

   function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] addr);
      return (addr == AW'(FIFO_DEPTH - 1)) ? '0 : addr + 1'b1;
   endfunction

   logic [N-1:0]     req_a_arr [NUM_REQ];
   logic [N-1:0]     req_b_arr [NUM_REQ];
   logic [ID_W-1:0]  grant_id;
   logic [ID_W-1:0]  search_idx;
   logic             grant_any;
   logic             credit_ok;
   logic             xfer;
   logic [CNT_W-1:0] inflight_cnt_reg, inflight_cnt_next;
   logic [CNT_W-1:0] fifo_cnt_reg, fifo_cnt_next;
   logic [LAT:0]     tag_valid_reg;
   logic [ID_W-1:0]  tag_id_reg [LAT+1];
   logic [N-1:0]     mul_a_reg, mul_b_reg;
   logic [N-1:0]     data_mem [FIFO_DEPTH];
   logic [ID_W-1:0]  id_mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
   logic             fifo_push, fifo_pop;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
         assign req_a_arr[gi] = req_a[gi*N +: N];
         assign req_b_arr[gi] = req_b[gi*N +: N];
         assign req_ready[gi] = xfer && (grant_id == ID_W'(gi));
      end
   endgenerate

`ifdef FP_MUL_ARB_FIXED_PRIO_EN
   always_comb begin
      grant_id   = '0;
      grant_any  = 1'b0;
      search_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!grant_any && req_valid[search_idx]) begin
            grant_id  = search_idx;
            grant_any = 1'b1;
         end
         search_idx = next_id(search_idx);
      end
   end
`else
   logic [ID_W-1:0] ptr_reg;

   // Search begins one past the last winner so every requester gets a turn.
   always_comb begin
      grant_id   = '0;
      grant_any  = 1'b0;
      search_idx = next_id(ptr_reg);
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!grant_any && req_valid[search_idx]) begin
            grant_id  = search_idx;
            grant_any = 1'b1;
         end
         search_idx = next_id(search_idx);
      end
   end

   always_ff @(posedge clk) begin
      if (rst)       ptr_reg <= ID_W'(NUM_REQ - 1);
      else if (xfer) ptr_reg <= grant_id;
   end
`endif

   // The multiplier cannot stall, so every in-flight op must already own a FIFO slot.
   assign credit_ok = ({1'b0, inflight_cnt_reg} + {1'b0, fifo_cnt_reg}) < (CNT_W+1)'(FIFO_DEPTH);
   assign xfer      = grant_any && credit_ok;
   assign fifo_push = tag_valid_reg[LAT];
   assign fifo_pop  = resp_valid && resp_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         mul_a_reg <= '0;
         mul_b_reg <= '0;
      end else if (xfer) begin
         mul_a_reg <= req_a_arr[grant_id];
         mul_b_reg <= req_b_arr[grant_id];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tag_valid_reg <= '0;
         for (int s = 0; s <= LAT; s++) tag_id_reg[s] <= '0;
      end else begin
         tag_valid_reg <= {tag_valid_reg[LAT-1:0], xfer};
         tag_id_reg[0] <= grant_id;
         for (int s = 1; s <= LAT; s++) tag_id_reg[s] <= tag_id_reg[s-1];
      end
   end

   always_comb begin
      inflight_cnt_next = inflight_cnt_reg;
      if (xfer && !fifo_push)      inflight_cnt_next = inflight_cnt_reg + 1'b1;
      else if (!xfer && fifo_push) inflight_cnt_next = inflight_cnt_reg - 1'b1;
      fifo_cnt_next = fifo_cnt_reg;
      if (fifo_push && !fifo_pop)      fifo_cnt_next = fifo_cnt_reg + 1'b1;
      else if (!fifo_push && fifo_pop) fifo_cnt_next = fifo_cnt_reg - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         inflight_cnt_reg <= '0;
         fifo_cnt_reg     <= '0;
         wr_ptr_reg       <= '0;
         rd_ptr_reg       <= '0;
      end else begin
         inflight_cnt_reg <= inflight_cnt_next;
         fifo_cnt_reg     <= fifo_cnt_next;
         if (fifo_push) wr_ptr_reg <= next_addr(wr_ptr_reg);
         if (fifo_pop)  rd_ptr_reg <= next_addr(rd_ptr_reg);
      end
   end

   always_ff @(posedge clk) begin
      if (fifo_push) begin
         data_mem[wr_ptr_reg] <= mul_result;
         id_mem[wr_ptr_reg]   <= tag_id_reg[LAT];
      end
   end

   assign mul_a      = mul_a_reg;
   assign mul_b      = mul_b_reg;
   assign resp_valid = (fifo_cnt_reg != '0);
   assign resp_data  = resp_valid ? data_mem[rd_ptr_reg] : '0;
   assign resp_id    = resp_valid ? id_mem[rd_ptr_reg] : '0;
   assign busy       = (inflight_cnt_reg != '0) || (fifo_cnt_reg != '0);
endmodule

// File: doc/fp_mul_arbiter.md
# fp_mul_arbiter

Shares one pipelined fp_multiplier instance among NUM_REQ requesters. Each requester uses a valid/ready handshake, and grants are round-robin. The block tags each issued operation with its requester ID, tracks the tag through the multiplier's fixed latency, and captures each result into a response FIFO. A credit check guarantees no result is lost, because the multiplier has no stall input.

## Interface
- N, 16: operand/result width; must match the multiplier's N.
- NUM_REQ, 4: number of requesters, 2..8.
- LAT, 3: multiplier latency in cycles from its a/b inputs being sampled to `result` being valid.
- FIFO_DEPTH, 8: response FIFO entries; must be at least LAT+3 for full throughput.
- ID_W: localparam, max(1, $clog2(NUM_REQ)).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset. The multiplier's rst_n is driven by ~rst at top level.
- req_valid  in  NUM_REQ  per-requester operation valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ*N  operand a; requester i uses bits [i*N +: N].
- req_b  in  NUM_REQ*N  operand b; same packing as req_a.
- mul_a  out  N  registered operand a to the multiplier.
- mul_b  out  N  registered operand b to the multiplier.
- mul_result  in  N  multiplier result.
- resp_valid  out  1  FIFO head valid.
- resp_ready  in  1  consumer accepts the head.
- resp_data  out  N  product at the FIFO head.
- resp_id  out  ID_W  requester index of the head.
- busy  out  1  high when any operation is in flight or the FIFO is non-empty.

## Operation
- Transfer from requester i occurs when req_valid[i] && req_ready[i].
- Credit rule: issue is allowed only if inflight_cnt + fifo_cnt < FIFO_DEPTH. Both counts are the registered values at the start of the cycle; a pop in the same cycle does not free credit until the next cycle.
- Grant: req_ready is driven combinationally from req_valid and the priority pointer.
  - Search starts at index ptr+1 and wraps modulo NUM_REQ.
  - The first valid index found gets req_ready.
  - If credit is unavailable, all req_ready are 0.
- ptr updates to the granted index only when a transfer occurs. Reset value of ptr is NUM_REQ-1, so requester 0 is searched first.
- On transfer:
  - mul_a/mul_b load the granted operands.
  - The tag pipeline stage 0 loads {valid=1, id}.
  - inflight_cnt increments.
- When there is no transfer, mul_a/mul_b hold their values and tag stage 0 loads valid=0.
- Tag pipeline: LAT+1 stages, shifting every cycle. When the tail stage is valid, {mul_result, tail id} is pushed into the FIFO and inflight_cnt decrements.
- FIFO: synchronous, first-word-fall-through, with wrap-around read/write pointers.
  - Head is shown on resp_data/resp_id; resp_valid = (fifo_cnt != 0).
  - Pop occurs on resp_valid && resp_ready.
  - Push and pop in the same cycle are both performed, and fifo_cnt is unchanged.
  - Push when full cannot occur because of the credit rule; the bench asserts it never happens.
- An increment and decrement of inflight_cnt in the same cycle leave it unchanged.
- busy = (inflight_cnt != 0) || (fifo_cnt != 0).

## Timing
- Reset values: req_ready = 0; mul_a = 0; mul_b = 0; resp_valid = 0; resp_data = 0; resp_id = 0; busy = 0. All tag valids, counts and FIFO pointers are 0.
- Reset in the middle of operation:
  - Clears the tag pipeline, FIFO and counters in the same edge.
  - Multiplier outputs that arrive later are discarded, because no tag is valid.
  - Operations accepted before reset are lost and never produce a response.
- Latency: a request accepted in cycle t gives mul_a valid in t+1 and mul_result valid in t+LAT+1. The earliest resp_valid is cycle t+LAT+2 (t+5 at default LAT).
- Throughput: one issue per cycle sustained when resp_ready is held high and FIFO_DEPTH >= LAT+3.
- Results are delivered in issue order; there is no reordering.

## Configuration
- FP_MUL_ARB_FIXED_PRIO_EN defined: fixed priority.
  - The lowest valid index always wins.
  - ptr is not implemented.
- FP_MUL_ARB_FIXED_PRIO_EN undefined (default): round-robin, as described in Operation.

## Test plan
The bench attaches a LAT-stage register stub computing (a*b) mod 2^N in place of the multiplier.
- Single request: requester 2 sends a=3, b=5 in cycle t with resp_ready=1 -> resp_valid in t+5 with resp_data=15, resp_id=2; busy falls the cycle after the pop.
- Round-robin: all 4 requesters valid continuously for 12 cycles -> grants are 0,1,2,3,0,1,2,3,... with one per cycle and resp_ids in the same order.
- Backpressure: resp_ready=0 with requester 0 always valid -> exactly 8 transfers, then req_ready stays 0. Raising resp_ready drains 8 responses in order, then issue resumes.
- Simultaneous push and pop: at steady state with resp_ready=1, fifo_cnt stays at 1 and no response is dropped or duplicated over 100 operations.
- Reset mid-flight: assert rst 2 cycles after issuing 3 ops -> no resp_valid for 10 cycles after release; a new request then completes with the correct data.
- Fixed-priority build with FP_MUL_ARB_FIXED_PRIO_EN defined: requesters 1 and 3 both valid -> requester 1 is granted every cycle and requester 3 is starved.
